// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator.
// Each channel counts enabled cycles up to a programmable terminal count.
// At terminal count it emits a one-cycle tick and toggles a square wave.
// In one-shot mode the channel then stops until its divisor is rewritten.
module game_tick_gen #(
    parameter int unsigned CH          = 2,
    parameter int unsigned W           = 23,
    parameter int unsigned DEFAULT_DIV = 999999
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] en,
    input  logic [CH-1:0] mode,
    input  logic [CH-1:0] div_wr,
    input  logic [W-1:0]  div_in,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] sq,
    output logic [CH-1:0] done
);

    localparam logic [W-1:0] RESET_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] CNT_ONE   = W'(1);

    logic [W-1:0] cnt [CH];
    logic [W-1:0] div [CH];

    // Per-channel terminal-count and count-advance qualifiers
    logic [CH-1:0] run_c;
    logic [CH-1:0] term_c;

    // Decode which channels advance this cycle and which reach terminal count
    always_comb begin
        run_c  = '0;
        term_c = '0;
        for (int i = 0; i < int'(CH); i++) begin
            run_c[i]  = en[i] & ~done[i];
            term_c[i] = run_c[i] & (cnt[i] == div[i]);
        end
    end

    // Channel state update: reset, then divisor write, then counting
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CH); i++) begin
                cnt[i] <= '0;
                div[i] <= RESET_DIV;
            end
            tick <= '0;
            sq   <= '0;
            done <= '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                if (div_wr[i]) begin
                    // A new divisor restarts the channel and re-arms one-shot mode
                    div[i]  <= div_in;
                    cnt[i]  <= '0;
                    done[i] <= 1'b0;
                    tick[i] <= 1'b0;
                end else if (term_c[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b1;
                    sq[i]   <= ~sq[i];
                    done[i] <= mode[i];
                end else if (run_c[i]) begin
                    cnt[i]  <= cnt[i] + CNT_ONE;
                    tick[i] <= 1'b0;
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_tick_gen.sv
// Self-checking bench for game_tick_gen: directed scenarios with literal
// expectations, then randomized traffic against a period-based model.
module tb_game_tick_gen;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 8;
    localparam int unsigned DD = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic [CH-1:0] mode;
    logic [CH-1:0] div_wr;
    logic [W-1:0]  div_in;
    logic [CH-1:0] tick;
    logic [CH-1:0] sq;
    logic [CH-1:0] done;

    int checks = 0;
    int errors = 0;

    // Model: enabled edges since arming, total ticks since reset, divisor, flags
    int ecnt [CH];
    int ntk  [CH];
    int mdiv [CH];
    bit mdone[CH];
    bit mtick[CH];

    game_tick_gen #(.CH(CH), .W(W), .DEFAULT_DIV(DD)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .div_wr (div_wr),
        .div_in (div_in),
        .tick   (tick),
        .sq     (sq),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance for one rising edge, from the input values at that edge
    task automatic model_edge();
        for (int i = 0; i < int'(CH); i++) begin
            if (rst) begin
                ecnt[i] = 0; ntk[i] = 0; mdiv[i] = int'(DD);
                mdone[i] = 1'b0; mtick[i] = 1'b0;
            end else if (div_wr[i]) begin
                mdiv[i] = int'(div_in); ecnt[i] = 0;
                mdone[i] = 1'b0; mtick[i] = 1'b0;
            end else if (en[i] && !mdone[i]) begin
                ecnt[i]++;
                if (ecnt[i] % (mdiv[i] + 1) == 0) begin
                    mtick[i] = 1'b1;
                    ntk[i]++;
                    mdone[i] = mode[i];
                end else begin
                    mtick[i] = 1'b0;
                end
            end else begin
                mtick[i] = 1'b0;
            end
        end
    endtask

    // One clock: advance model at the edge, compare all outputs 1ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < int'(CH); i++) begin
            chk($sformatf("model_tick[%0d]", i), int'(tick[i]), int'(mtick[i]));
            chk($sformatf("model_sq[%0d]", i),   int'(sq[i]),   ntk[i] % 2);
            chk($sformatf("model_done[%0d]", i), int'(done[i]), int'(mdone[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; div_wr = '0; mode = '0; div_in = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = '0; div_wr = '0; div_in = '0;

        // Reset state and free-running default divisor of 3
        do_reset();
        chk("rst_tick", int'(tick), 0);
        chk("rst_sq",   int'(sq),   0);
        chk("rst_done", int'(done), 0);
        en = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("fr_tick0_k%0d", k), int'(tick[0]), (k % 4 == 0) ? 1 : 0);
            if (k == 4)  chk("fr_sq0_t1", int'(sq[0]), 1);
            if (k == 8)  chk("fr_sq0_t2", int'(sq[0]), 0);
            if (k == 12) chk("fr_sq0_t3", int'(sq[0]), 1);
            chk($sformatf("fr_ch1_k%0d", k), int'({tick[1], sq[1], done[1]}), 0);
        end

        // div=0: tick every enabled cycle, sq toggles each cycle (starts at 1)
        en = '0; div_wr = 2'b01; div_in = 8'd0;
        step();
        chk("d0_wr_sq_hold", int'(sq[0]), 1);
        div_wr = '0; en = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("d0_tick_k%0d", k), int'(tick[0]), 1);
            chk($sformatf("d0_sq_k%0d", k),   int'(sq[0]),   (k % 2 == 0) ? 1 : 0);
        end

        // One-shot on channel 1 with div=2
        do_reset();
        div_wr = 2'b10; div_in = 8'd2; mode = 2'b10; en = 2'b10;
        step();
        div_wr = '0;
        for (int k = 1; k <= 23; k++) begin
            step();
            chk($sformatf("os_tick1_k%0d", k), int'(tick[1]), (k == 3) ? 1 : 0);
            chk($sformatf("os_done1_k%0d", k), int'(done[1]), (k >= 3) ? 1 : 0);
        end
        en = 2'b00; step(); en = 2'b10; step();
        chk("os_en_no_rearm", int'(done[1]), 1);
        div_wr = 2'b10;
        step();
        chk("os_rearm_done", int'(done[1]), 0);
        div_wr = '0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("os_rearm_tick_k%0d", k), int'(tick[1]), (k == 3) ? 1 : 0);
        end

        // Enable dropped at cnt=2 for 5 cycles
        do_reset();
        en = 2'b01;
        step(); step();
        en = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("pause_tick_k%0d", k), int'(tick[0]), 0);
        end
        en = 2'b01;
        step(); chk("pause_resume1", int'(tick[0]), 0);
        step(); chk("pause_resume2", int'(tick[0]), 1);

        // Divisor write on the terminal-count edge suppresses the tick
        do_reset();
        en = 2'b01;
        step(); step(); step();
        div_wr = 2'b01; div_in = 8'd5;
        step();
        chk("wr_tc_tick", int'(tick[0]), 0);
        div_wr = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("wr_tc_next_k%0d", k), int'(tick[0]), (k == 6) ? 1 : 0);
        end

        // Reset mid-count with div=5 restores div=3
        do_reset();
        div_wr = 2'b01; div_in = 8'd5;
        step();
        div_wr = '0; en = 2'b01;
        step(); step();
        rst = 1'b1;
        step();
        chk("midrst_tick", int'(tick[0]), 0);
        chk("midrst_sq",   int'(sq[0]),   0);
        chk("midrst_done", int'(done[0]), 0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("midrst_tick_k%0d", k), int'(tick[0]), (k == 4) ? 1 : 0);
        end

        // Randomized traffic, including occasional full-range divisor
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < int'(CH); i++) begin
                en[i]     = ($urandom_range(0, 3) != 0);
                div_wr[i] = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 15) == 0) mode[i] = ~mode[i];
            end
            if ($urandom_range(0, 30) == 0) div_in = 8'hFF;
            else div_in = W'($urandom_range(0, 6));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_tick_gen.md
GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 The block SHALL provide parameter CH, default 2, meaning the number of independent tick channels (1..8).
REQ-002 The block SHALL provide parameter W, default 23, meaning the counter and divisor width in bits.
REQ-003 The block SHALL provide parameter DEFAULT_DIV, default 999999, meaning the terminal count loaded into every channel at reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, CH bits: per-channel count enable.
REQ-007 The block SHALL have port mode, input, CH bits: per-channel mode; 0 = free-running, 1 = one-shot.
REQ-008 The block SHALL have port div_wr, input, CH bits: per-channel one-cycle divisor write strobe.
REQ-009 The block SHALL have port div_in, input, W bits: divisor value, shared by all channels and captured by every channel whose div_wr bit is 1.
REQ-010 The block SHALL have port tick, output, CH bits: registered one-cycle pulse per channel at terminal count.
REQ-011 The block SHALL have port sq, output, CH bits: registered square wave per channel; it toggles at each tick.
REQ-012 The block SHALL have port done, output, CH bits: registered flag set while a one-shot channel has fired and not yet been re-armed.

Function
REQ-013 Each channel SHALL hold a W-bit counter cnt and a W-bit divisor div; channels are fully independent.
REQ-014 Priority per channel per edge SHALL be: rst > div_wr > count.
REQ-015 On div_wr[i]=1, the channel SHALL do the following on that edge: div<=div_in, cnt<=0, done<=0, tick<=0; sq holds, and any terminal count that edge is suppressed.
REQ-016 When en[i]=1, done[i]=0 and cnt==div, the channel SHALL do the following on that edge: cnt<=0, tick<=1, sq<=~sq, and done<=mode[i].
REQ-017 When en[i]=1, done[i]=0 and cnt!=div, the channel SHALL do the following on that edge: cnt<=cnt+1 and tick<=0.
REQ-018 When en[i]=0 or done[i]=1, the channel SHALL hold cnt, sq and done, and drive tick<=0.
REQ-019 Tick period in free-running mode SHALL be div+1 enabled cycles; the sq period SHALL be 2*(div+1) enabled cycles.
REQ-020 With div=0, the channel SHALL assert tick on every enabled cycle, and sq SHALL toggle every enabled cycle.
REQ-021 With div=2^W-1, cnt SHALL reach the all-ones value and then wrap to 0 with a tick, never overflowing.
REQ-022 tick SHALL be high for exactly one cycle per terminal count, never two consecutive cycles unless div=0.
REQ-023 In one-shot mode, a channel with done=1 SHALL re-arm only via div_wr; toggling en SHALL NOT re-arm it.
REQ-024 A change of mode[i] mid-count SHALL take effect at the next terminal count only.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-026 On any edge with rst=1, every channel SHALL take cnt=0, div=DEFAULT_DIV, tick=0, sq=0, done=0, regardless of en, div_wr or mode.
REQ-027 The first count SHALL occur on the first edge with rst=0 and en=1.
REQ-028 rst asserted mid-count SHALL discard the partial count and any divisor written after the previous reset.

Verification (CH=2, W=8, DEFAULT_DIV=3)
REQ-029 The bench SHALL cover: rst, then en=01 with mode=00 -> tick[0] high after the 4th, 8th and 12th enabled edges; sq[0] reads 1,0,1 after those ticks; channel 1 stays all zero.
REQ-030 The bench SHALL cover: div_wr=01 with div_in=0, then en=01 -> tick[0] high every cycle, and sq[0] alternates every cycle.
REQ-031 The bench SHALL cover: div_wr=10 with div_in=2, mode=10, en=10 -> a single tick[1] after the 3rd edge, done[1]=1 thereafter, and no further ticks over 20 cycles; a div_wr[1] pulse clears done[1] and the next tick follows 3 edges later.
REQ-032 The bench SHALL cover: en[0] dropped when cnt=2 for 5 cycles, then restored -> no tick while low, and tick[0] fires on the 2nd edge after restore.
REQ-033 The bench SHALL cover: div_wr[0] with div_in=5 on the same edge as terminal count -> no tick that edge, cnt=0, and the next tick after 6 enabled edges.
REQ-034 The bench SHALL cover: rst pulsed for one cycle when cnt=2 and div=5 -> the next cycle shows tick=0, sq=0, done=0, and the next tick occurs after 4 enabled edges (div back to 3).
